// File: rtl/c3lib_rst_seq_pkg.sv
// c3lib_rst_seq_pkg: shared types and sizing helpers for the reset release sequencer.
//   rst_seq_state_e : sequencer state encoding
//   count_width()   : bits needed to hold the values 0 .. n-1 (minimum 1)
package c3lib_rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT   = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2,
    ERR      = 2'd3
  } rst_seq_state_e;

  // Width of a counter or index that ranges over 0 .. n-1.
  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/c3lib_rst_seq_if.sv
// c3lib_rst_seq_if: sequencer-side bundle of per-stage reset controls.
//   sw_rst_req  : single-cycle request to re-run the release sequence
//   stage_ack   : per-stage ready acknowledge (level, clk-synchronous)
//   stage_rst_n : per-stage active-low reset
//   seq_done    : every stage released and acknowledged
//   timeout_err : sticky acknowledge timeout flag
// master = the sequencer, slave = the reset domains / controlling logic.
interface c3lib_rst_seq_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  timeout_err;

  modport master (
    input  sw_rst_req,
    input  stage_ack,
    output stage_rst_n,
    output seq_done,
    output timeout_err
  );

  modport slave (
    output sw_rst_req,
    output stage_ack,
    input  stage_rst_n,
    input  seq_done,
    input  timeout_err
  );
endinterface

// File: rtl/c3lib_rst_sync.sv
// c3lib_rst_sync: reset deassertion synchronizer. Asserts asynchronously with
// rst_n, deasserts after SYNC_DEPTH clk edges. Kept as its own cell so the
// hardened flop chain is preserved untouched through synthesis.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   sync_rst_n : synchronized reset, high SYNC_DEPTH edges after rst_n release
module c3lib_rst_sync #(
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Shift a constant 1 through the chain once reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/c3lib_rst_seq.sv
// c3lib_rst_seq: reset release sequencer. Holds every downstream domain in
// reset, then releases stages one at a time after a synchronized hold period,
// advancing only when the current stage acknowledges. A missing acknowledge
// raises a sticky timeout and freezes the sequence until sw_rst_req or rst_n.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of c3lib_rst_seq_if (sw_rst_req, stage_ack in;
//           stage_rst_n, seq_done, timeout_err out, all flop-driven)
module c3lib_rst_seq
  import c3lib_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned SYNC_DEPTH  = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  c3lib_rst_seq_if.master        bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CW      = count_width(CNT_MAX);
  localparam int unsigned IW      = count_width(NUM_STAGES);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  rst_seq_state_e        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  sync_rst_n;
  logic                  ack_cur_c;

  c3lib_rst_sync #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n)
  );

  // Only the acknowledge of the stage currently being waited on matters.
  assign ack_cur_c = |(bus.stage_ack & (NUM_STAGES'(1) << idx_q));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output logic; sw_rst_req outranks ack, ack outranks timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    err_d   = err_q;

    if (bus.sw_rst_req) begin
      // Synchronizer is left alone, so the hold period starts right away.
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          if (!sync_rst_n) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            stage_d = NUM_STAGES'(1);
            idx_d   = '0;
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_ACK: begin
          if (ack_cur_c) begin
            if (idx_q == IDX_LAST) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              stage_d = stage_q | (NUM_STAGES'(1) << (idx_q + IW'(1)));
              idx_d   = idx_q + IW'(1);
              cnt_d   = '0;
            end
          end else if (cnt_q == ACK_LAST) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_d = DONE;
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
  end

  assign bus.stage_rst_n = stage_q;
  assign bus.seq_done    = done_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_c3lib_rst_seq.sv
// tb_c3lib_rst_seq: directed plus randomized checks of c3lib_rst_seq against a
// timeline model: each trial is described by per-stage ack delays, from which
// the release edge of every stage, the done edge and the timeout edge follow.
module tb_c3lib_rst_seq;

  localparam int NS    = 4;
  localparam int SD    = 2;
  localparam int HC    = 4;
  localparam int AT    = 16;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  c3lib_rst_seq_if #(.NUM_STAGES(NS)) bus ();

  c3lib_rst_seq #(
    .NUM_STAGES  (NS),
    .SYNC_DEPTH  (SD),
    .HOLD_CYCLES (HC),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int t;                       // index of the most recent clk edge
  int checks = 0;
  int errors = 0;

  // Trial description and derived timeline.
  int d [NS];                  // edges after release at which the stage ack is first seen (>AT: never)
  int r [NS];                  // release edge per stage
  int nrel;                    // stages that get released in this trial
  int done_e, err_e, end_e;

  task automatic plan(input int r0);
    int tt;
    tt = r0;
    nrel   = 0;
    done_e = NEVER;
    err_e  = NEVER;
    for (int i = 0; i < NS; i++) r[i] = NEVER;
    for (int i = 0; i < NS; i++) begin
      r[i] = tt;
      nrel = i + 1;
      if (d[i] > AT) begin
        err_e = tt + AT;
        break;
      end
      tt = tt + d[i];
      if (i == NS - 1) done_e = tt;
    end
    end_e = (done_e < err_e) ? done_e : err_e;
  endtask

  // Ack levels to be sampled at edge te; finished stages get random noise.
  task automatic drive_acks(input int te);
    logic [NS-1:0] a;
    a = '0;
    for (int i = 0; i < NS; i++) begin
      if (i < nrel && d[i] <= AT) begin
        if (te == r[i] + d[i])     a[i] = 1'b1;
        else if (te > r[i] + d[i]) a[i] = 1'($urandom_range(0, 1));
      end
    end
    bus.stage_ack = a;
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic check_vals(input string tag, input logic [NS-1:0] es, input logic ed, input logic ee);
    checks += 3;
    assert (bus.stage_rst_n === es) else begin
      errors++;
      $error("FAIL %s stage_rst_n edge=%0d got=%b exp=%b", tag, t, bus.stage_rst_n, es);
    end
    assert (bus.seq_done === ed) else begin
      errors++;
      $error("FAIL %s seq_done edge=%0d got=%b exp=%b", tag, t, bus.seq_done, ed);
    end
    assert (bus.timeout_err === ee) else begin
      errors++;
      $error("FAIL %s timeout_err edge=%0d got=%b exp=%b", tag, t, bus.timeout_err, ee);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NS-1:0] es;
    es = '0;
    for (int i = 0; i < NS; i++) es[i] = (i < nrel) && (t >= r[i]);
    check_vals(tag, es, t >= done_e, t >= err_e);
  endtask

  task automatic run_trial(input string tag, input int max_cyc);
    for (int c = 0; c < max_cyc && t < end_e + 3; c++) begin
      drive_acks(t + 1);
      tick();
      check_model(tag);
    end
  endtask

  task automatic sw_restart(input string tag);
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    plan(t + HC);
    check_model(tag);
  endtask

  task automatic set_d(input int d0, input int d1, input int d2, input int d3);
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
  endtask

  initial begin
    t              = 0;
    rst_n          = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.stage_ack  = '0;

    // Reset values with no clock edge yet.
    #2;
    check_vals("reset", '0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    // Power-on with every ack already high.
    set_d(1, 1, 1, 1);
    plan(SD + HC);
    run_trial("power_on", 40);

    // Restart from DONE with a late stage-1 ack.
    set_d(1, 5, 1, 1);
    sw_restart("delayed_ack");
    run_trial("delayed_ack", 60);

    // Stage 2 never acknowledges.
    set_d(1, 1, AT + 4, 1);
    sw_restart("timeout");
    run_trial("timeout", 60);

    // Restart from ERR; acks land exactly on the timeout edge.
    set_d(1, AT, 2, AT);
    sw_restart("ack_on_timeout");
    run_trial("ack_on_timeout", 80);

    // sw_rst_req during the hold period restarts the hold count.
    set_d(2, 1, 3, 1);
    sw_restart("sw_in_assert");
    run_trial("sw_in_assert", 2);
    sw_restart("sw_in_assert");
    run_trial("sw_in_assert", 60);

    // rst_n pulsed between edges while waiting on stage 1.
    set_d(3, 3, 3, 3);
    sw_restart("rst_pulse");
    run_trial("rst_pulse", 5);
    #2 rst_n = 1'b0;
    #1 check_vals("rst_async", '0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    set_d(1, 2, 1, 2);
    plan(t + SD + HC);
    run_trial("rst_pulse_rerun", 60);

    // Randomized ack delays, some exceeding the timeout.
    repeat (25) begin
      for (int i = 0; i < NS; i++) d[i] = int'($urandom_range(1, AT + 2));
      sw_restart("random");
      run_trial("random", 120);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c3lib_rst_seq.md
# c3lib_rst_seq

Reset release sequencer. It sits directly upstream of the c3lib asynchronous-set/reset flop primitives and produces their `rst_n` inputs. It asserts all downstream domain resets asynchronously. It releases them one stage at a time, each release synchronous to `clk`, after a synchronized hold period. Each next stage is released only after the previous stage acknowledges readiness; a timeout is flagged if an acknowledge never arrives.

## Interface
- `NUM_STAGES`, default 4: number of sequenced reset outputs (≥1).
- `SYNC_DEPTH`, default 2: reset-deassertion synchronizer depth (≥2).
- `HOLD_CYCLES`, default 4: cycles reset is held after the synchronized deassertion (≥1).
- `ACK_TIMEOUT`, default 16: cycles allowed per stage for an acknowledge (≥2).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw_rst_req` in 1: synchronous single-cycle request to re-run the sequence.
- `stage_ack` in `NUM_STAGES`: per-stage ready acknowledge, already synchronous to `clk`, level.
- `stage_rst_n` out `NUM_STAGES`: per-stage reset, active-low, driven directly from flops.
- `seq_done` out 1: all stages released and acknowledged.
- `timeout_err` out 1: sticky; a stage did not acknowledge within `ACK_TIMEOUT`.

## Operation
- Reset values: `stage_rst_n`=0 for all stages, `seq_done`=0, `timeout_err`=0, state=ASSERT, stage index=0, counter=0.
- Synchronizer: a chain of `SYNC_DEPTH` flops, cleared asynchronously by `rst_n`, with D=1. Its output is `sync_rst_n`.
- States: ASSERT, WAIT_ACK, DONE, ERR.
- ASSERT:
  - All `stage_rst_n`=0.
  - The counter holds at 0 while `sync_rst_n`=0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches `HOLD_CYCLES`-1: set `stage_rst_n[0]`=1, set idx=0, clear the counter, go to WAIT_ACK.
- WAIT_ACK:
  - If `stage_ack[idx]`=1 and idx<`NUM_STAGES`-1: set `stage_rst_n[idx+1]`=1, increment idx, clear the counter.
  - If `stage_ack[idx]`=1 and idx=`NUM_STAGES`-1: go to DONE.
  - If `stage_ack[idx]`=0: increment the counter. When the counter reaches `ACK_TIMEOUT`-1, go to ERR.
- DONE: `seq_done`=1. All `stage_rst_n` stay at 1.
- ERR:
  - `timeout_err`=1.
  - Released stages keep `stage_rst_n`=1; unreleased stages stay at 0.
  - The state holds until `sw_rst_req` or `rst_n`.
- `sw_rst_req`, in any state other than ASSERT:
  - Next edge: all `stage_rst_n`=0, `seq_done`=0, `timeout_err`=0, counter=0, idx=0, state=ASSERT.
  - The synchronizer is not affected, so the hold period restarts immediately.
- `sw_rst_req` in ASSERT: restarts the hold counter.
- Priority per edge: `rst_n` > `sw_rst_req` > ack > timeout. An ack on the timeout cycle is accepted.
- Acks for stages other than idx are ignored. An ack already high on release is accepted on the first WAIT_ACK edge.
- `stage_rst_n` bits only transition 0→1 synchronously. 1→0 happens only via `rst_n` (async) or `sw_rst_req` (sync). Outputs are glitch-free.

## Timing
- `rst_n` assertion: all outputs reach their reset values immediately, with no clock needed.
- `rst_n` deassertion before edge 1: `sync_rst_n` is high after edge `SYNC_DEPTH`. `stage_rst_n[0]` rises after edge `SYNC_DEPTH`+`HOLD_CYCLES`. With defaults this is edge 6.
- Ack sampled high at edge e: the next stage rises after edge e. `seq_done` rises after edge e for the last stage.
- No ack: ERR is entered `ACK_TIMEOUT` edges after the stage's release.
- `sw_rst_req` at edge e (from DONE): `stage_rst_n[0]` rises after edge e+`HOLD_CYCLES`.
- Reset mid-sequence: immediate return to the reset values.

## Structure
- Package `c3lib_rst_seq_pkg`: state enum `rst_seq_state_e` (ASSERT, WAIT_ACK, DONE, ERR) and a width helper function for the counter and idx, sized to max(`HOLD_CYCLES`, `ACK_TIMEOUT`) and `NUM_STAGES`.
- Sub-module `c3lib_rst_sync`: parameterized `SYNC_DEPTH` deassertion synchronizer. It is the cell-hardening boundary, and the synthesis flow applies don't-touch to it.

## Test plan
- Power-on: `rst_n` low→high before edge 1, all acks=1. `stage_rst_n` goes 0001 after edge 6, 0011 after edge 7, 0111 after edge 8, 1111 after edge 9. `seq_done`=1 after edge 10.
- Delayed ack: stage 1 ack arrives 5 cycles after its release. `stage_rst_n[2]` rises after the ack edge; `timeout_err` stays 0.
- Timeout: `stage_ack[2]` held 0. ERR is entered 16 edges after `stage_rst_n[2]` rises. `timeout_err`=1, `stage_rst_n`=0111. Then `sw_rst_req` clears all outputs to 0.
- Ack on the timeout cycle: ack rises on the 16th edge. It is accepted, with no error.
- `sw_rst_req` in DONE: all `stage_rst_n`=0 the next edge, `stage_rst_n[0]` rises 4 edges later, and the full sequence repeats.
- `rst_n` pulsed low mid-WAIT_ACK, between clock edges: outputs clear asynchronously and the sequence restarts with the full `SYNC_DEPTH`+`HOLD_CYCLES` latency.
